pow_cntr: RTL and testbench

Parameterizable single-clock up/down counter, the basic pointer/occupancy primitive of the powlib library.
- Synchronous FIFOs use it for write/read pointers (clear-on-wrap) and for the fill-level counter (signed step of +1/−1/0).
- Async-FIFO controllers use it as a free-running next-pointer generator (INIT=1).
- Output is a registered count; all control is sampled on the rising clock edge.

---
 rtl/pow_pkg.sv | 22 ++
 rtl/pow_cntr_next.sv | 43 ++++
 rtl/pow_cntr.sv | 43 ++++
 tb/tb_pow_cntr.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pow_pkg.sv
// rtl/pow_pkg.sv - shared constants and helpers for the powlib counter family
package pow_pkg;

    // Step encodings for callers driving dx; truncate to the counter width at use.
    localparam int STEP_INC  = 1;
    localparam int STEP_DEC  = -1;
    localparam int STEP_HOLD = 0;

    // Bits needed to index n entries; pointer users size their counters with this.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pow_cntr_next.sv
// rtl/pow_cntr_next.sv - next-count logic for pow_cntr; load path gated by POW_CNTR_LOAD_EN
module pow_cntr_next
    import pow_pkg::*;
#(
    parameter int W   = 16,
    parameter int EDX = 0
) (
    input  logic [W-1:0] cntr,
    input  logic         adv,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] nval,
    input  logic [W-1:0] dx,
    output logic [W-1:0] nxt
);

    logic [W-1:0] step;

    assign step = (EDX != 0) ? dx : W'(STEP_INC);

`ifndef POW_CNTR_LOAD_EN
    // Load port is kept for a uniform port list but carries no logic in this build.
    logic unused_load;
    assign unused_load = ld ^ (^nval);
`endif

    // Clear beats load beats advance, so wrap-at-(D-1) pointers never clear-then-step.
    always_comb begin
        nxt = cntr;
        if (clr) begin
            nxt = '0;
        end
`ifdef POW_CNTR_LOAD_EN
        else if (ld) begin
            nxt = nval;
        end
`endif
        else if (adv) begin
            nxt = cntr + step;
        end
    end

endmodule

// File: rtl/pow_cntr.sv
// rtl/pow_cntr.sv - registered up/down counter; optional load via POW_CNTR_LOAD_EN
module pow_cntr
    import pow_pkg::*;
#(
    parameter int W    = 16,
    parameter int INIT = 0,
    parameter int EDX  = 0
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cntr,
    input  logic         adv,
    input  logic         clr,
    input  logic [W-1:0] dx,
    input  logic         ld,
    input  logic [W-1:0] nval
);

    logic [W-1:0] nxt;

    pow_cntr_next #(
        .W   (W),
        .EDX (EDX)
    ) u_next (
        .cntr (cntr),
        .adv  (adv),
        .clr  (clr),
        .ld   (ld),
        .nval (nval),
        .dx   (dx),
        .nxt  (nxt)
    );

    // Reset is tested first so unknown control inputs cannot leak past it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cntr <= W'(INIT);
        end else begin
            cntr <= nxt;
        end
    end

endmodule

// File: tb/tb_pow_cntr.sv
// tb/tb_pow_cntr.sv - randomized and directed check of pow_cntr against a reference model
module tb_pow_cntr;

    localparam int N = 4;
    localparam int PW[N]   = '{4, 3, 3, 4};
    localparam int PINIT[N] = '{1, 0, 0, 3};
    localparam int PEDX[N] = '{0, 0, 1, 1};

`ifdef POW_CNTR_LOAD_EN
    localparam bit LOAD_ON = 1'b1;
`else
    localparam bit LOAD_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       adv;
    logic       clr;
    logic       ld;
    logic [3:0] dx;
    logic [3:0] nval;

    logic [3:0] ca;
    logic [2:0] cb;
    logic [2:0] cc;
    logic [3:0] cd;
    int         q[N];

    int  model[N];
    bit  check_en;
    int  vectors;
    int  miscompares;

    pow_cntr #(.W(4), .INIT(1), .EDX(0)) u_a (
        .clk(clk), .rst(rst), .cntr(ca), .adv(adv), .clr(clr),
        .dx(dx), .ld(ld), .nval(nval)
    );
    pow_cntr #(.W(3), .INIT(0), .EDX(0)) u_b (
        .clk(clk), .rst(rst), .cntr(cb), .adv(adv), .clr(clr),
        .dx(dx[2:0]), .ld(ld), .nval(nval[2:0])
    );
    pow_cntr #(.W(3), .INIT(0), .EDX(1)) u_c (
        .clk(clk), .rst(rst), .cntr(cc), .adv(adv), .clr(clr),
        .dx(dx[2:0]), .ld(ld), .nval(nval[2:0])
    );
    pow_cntr #(.W(4), .INIT(3), .EDX(1)) u_d (
        .clk(clk), .rst(rst), .cntr(cd), .adv(adv), .clr(clr),
        .dx(dx), .ld(ld), .nval(nval)
    );

    always_comb begin
        q[0] = int'(ca);
        q[1] = int'(cb);
        q[2] = int'(cc);
        q[3] = int'(cd);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: counting modulo 2^W, with the documented priority order.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            int m;
            m = (1 << PW[i]);
            if (!rst)                 model[i] = PINIT[i] % m;
            else if (clr)             model[i] = 0;
            else if (LOAD_ON && ld)   model[i] = int'(nval) % m;
            else if (adv)             model[i] = (model[i] + (PEDX[i] != 0 ? int'(dx) : 1)) % m;
        end
        check_en = 1'b1;
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (q[i] != model[i]) begin
                    miscompares++;
                    $display("FAIL model_cmp inst%0d t=%0t got=%0d exp=%0d", i, $time, q[i], model[i]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic pin(input int idx, input int exp, input string name);
        vectors++;
        if (q[idx] != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", name, q[idx], exp);
        end
    endtask

    task automatic set(input bit r, input bit a, input bit c, input bit l,
                       input int d, input int n);
        rst  = r;
        adv  = a;
        clr  = c;
        ld   = l;
        dx   = 4'(d);
        nval = 4'(n);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        check_en = 1'b0;
        for (int i = 0; i < N; i++) model[i] = 0;

        // Reset held with adv high, then release.
        set(0, 1, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin cyc(); pin(0, 1, "reset_hold"); end
        set(1, 1, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin cyc(); pin(0, 2 + k, "reset_release"); end

        // Wrap on a 3-bit counter.
        set(0, 0, 0, 0, 1, 0); cyc();
        set(1, 1, 0, 0, 1, 0);
        for (int k = 0; k < 9; k++) begin cyc(); pin(1, (k + 1) % 8, "wrap"); end

        // Clear beats advance.
        set(0, 0, 0, 0, 1, 0); cyc();
        set(1, 1, 0, 0, 1, 0);
        for (int k = 0; k < 7; k++) cyc();
        pin(1, 7, "count_to_7");
        set(1, 1, 1, 0, 1, 0); cyc(); pin(1, 0, "clr_over_adv");
        set(1, 1, 0, 0, 1, 0); cyc(); pin(1, 1, "adv_after_clr");

        // Signed step.
        set(0, 0, 0, 0, 1, 0); cyc();
        set(1, 1, 0, 0, 1, 0); cyc(); pin(2, 1, "dx_plus1");
        set(1, 1, 0, 0, 7, 0); cyc(); pin(2, 0, "dx_minus1");
        set(1, 1, 0, 0, 7, 0); cyc(); pin(2, 7, "dx_underflow");
        set(1, 1, 0, 0, 0, 0); cyc(); pin(2, 7, "dx_zero_hold");
        set(1, 0, 0, 0, 1, 0); cyc(); pin(2, 7, "no_adv_hold");

        // Load versus advance and clear.
        set(0, 0, 0, 0, 1, 0); cyc();
        set(1, 1, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) cyc();
        pin(0, 5, "count_to_5");
        set(1, 1, 0, 1, 1, 10); cyc(); pin(0, LOAD_ON ? 10 : 6, "ld_over_adv");
        set(1, 1, 1, 1, 1, 10); cyc(); pin(0, 0, "clr_over_ld");

        // Reset in the middle of counting.
        set(0, 0, 0, 0, 1, 0); cyc();
        set(1, 1, 0, 0, 1, 0);
        for (int k = 0; k < 6; k++) cyc();
        pin(3, 9, "count_to_9");
        set(0, 1, 0, 0, 1, 0); cyc(); pin(3, 3, "mid_reset");
        set(1, 1, 0, 0, 1, 0); cyc(); pin(3, 4, "after_mid_reset");

        // Random traffic, checked every cycle by the compare process.
        for (int k = 0; k < 3000; k++) begin
            set(($urandom % 25) != 0, $urandom % 2 == 1, ($urandom % 9) == 0,
                ($urandom % 7) == 0, int'($urandom % 16), int'($urandom % 16));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
